spi_main_multi: RTL

Parametrised SPI master that succeeds the fixed-width AES-link master. It adds configurable frame widths, N chip selects, all four SPI modes selected per transfer, a programmable SCLK divider, and a sel range check. It sits between the AES control logic and one or more SPI subordinates. It shifts a TX_W-bit frame out on mosi while capturing RX_W bits from the selected miso line.

---
 rtl/spi_main_multi.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_main_multi.sv
// rtl/spi_main_multi.sv - parametrised multi-chip-select SPI master, all four modes per transfer
// Optional build macro SPI_MAIN_LSB_FIRST_EN selects LSB-first framing in both directions.
module spi_main_multi #(
   parameter int TX_W   = 258,
   parameter int RX_W   = 128,
   parameter int NUM_CS = 2,
   parameter int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
   parameter int DIV    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SEL_W-1:0]  sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [TX_W-1:0]   tx,
   input  logic [NUM_CS-1:0] miso,
   output logic [RX_W-1:0]   rx,
   output logic [NUM_CS-1:0] cs_n,
   output logic              sclk,
   output logic              mosi,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int DIV_CW = $clog2(DIV + 1);
   localparam int BIT_CW = $clog2(TX_W + 1);

   if (RX_W < 1 || RX_W > TX_W) begin : g_bad_rx_w
      $error("spi_main_multi: RX_W must satisfy 1 <= RX_W <= TX_W");
   end
   if (DIV < 1) begin : g_bad_div
      $error("spi_main_multi: DIV must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t              state, state_nxt;
   logic [TX_W-1:0]     tx_sr;
   logic [RX_W-1:0]     rx_sr;
   logic [RX_W-1:0]     rx_q;
   logic [SEL_W-1:0]    sel_q;
   logic                cpol_q, cpha_q, sclk_q, err_q;
   logic [DIV_CW-1:0]   div_cnt;
   logic [BIT_CW-1:0]   bit_cnt;

   logic active, sel_ok, accept, div_done, last_bit_done;
   logic edge_fire, leading, sample, keep, shift_tx, miso_bit;

   assign active        = (state == SETUP) || (state == SHIFT) || (state == HOLD);
   assign sel_ok        = int'(sel) < NUM_CS;
   assign accept        = (state == IDLE) && start && sel_ok;
   assign div_done      = (div_cnt == DIV_CW'(DIV - 1));
   assign last_bit_done = (bit_cnt == BIT_CW'(TX_W));
   // One sclk edge per half-period; the SETUP->SHIFT boundary is the first (leading) edge.
   assign edge_fire     = div_done && ((state == SETUP) || ((state == SHIFT) && !last_bit_done));
   assign leading       = (sclk_q == cpol_q);
   assign sample        = edge_fire && (leading ^ cpha_q);
   assign keep          = (bit_cnt < BIT_CW'(RX_W));
   assign shift_tx      = edge_fire && (cpha_q ? (leading && (bit_cnt != '0))
                                               : (!leading && (bit_cnt != BIT_CW'(TX_W - 1))));
   assign miso_bit      = |(miso & (NUM_CS'(1) << sel_q));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   if (div_done) state_nxt = SHIFT;
         SHIFT:   if (div_done && last_bit_done) state_nxt = HOLD;
         HOLD:    if (div_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_sr   <= '0;
         rx_sr   <= '0;
         rx_q    <= '0;
         sel_q   <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         sclk_q  <= 1'b0;
         err_q   <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         err_q <= (state == IDLE) && start && !sel_ok;
         if (accept) begin
            tx_sr   <= tx;
            rx_sr   <= '0;
            sel_q   <= sel;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            sclk_q  <= cpol;
            bit_cnt <= '0;
         end else begin
            if (edge_fire) sclk_q <= ~sclk_q;
            if (edge_fire && !leading) bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_MAIN_LSB_FIRST_EN
            if (shift_tx) tx_sr <= tx_sr >> 1;
            if (sample && keep) rx_sr <= (rx_sr >> 1) | (RX_W'(miso_bit) << (RX_W - 1));
`else
            if (shift_tx) tx_sr <= tx_sr << 1;
            if (sample && keep) rx_sr <= (rx_sr << 1) | RX_W'(miso_bit);
`endif
         end
         if (!active || div_done) div_cnt <= '0;
         else                     div_cnt <= div_cnt + 1'b1;
         if ((state == HOLD) && div_done) rx_q <= rx_sr;
      end
   end

   assign rx   = rx_q;
   assign cs_n = active ? ~(NUM_CS'(1) << sel_q) : '1;
   assign sclk = sclk_q;
`ifdef SPI_MAIN_LSB_FIRST_EN
   assign mosi = active ? tx_sr[0] : 1'b0;
`else
   assign mosi = active ? tx_sr[TX_W-1] : 1'b0;
`endif
   assign busy = active;
   assign done = (state == DONE);
   assign err  = err_q;

endmodule
